// File: rtl/cfu_pkg.sv
// Shared constants and types for the requantization CFU stage.
// Holds command codes, FSM states and configuration reset values.
package cfu_pkg;

    localparam logic [6:0] FN_REQUANT   = 7'd0;
    localparam logic [6:0] FN_SET_SCALE = 7'd1;
    localparam logic [6:0] FN_SET_OUT   = 7'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADD,
        ST_MUL,
        ST_RND,
        ST_RESP
    } state_t;

    localparam logic [31:0] MULT_RESET       = 32'd0;
    localparam logic [5:0]  SHIFT_RESET      = 6'd0;
    localparam logic [15:0] OUT_OFFSET_RESET = 16'd0;
    localparam logic [7:0]  ACT_MIN_RESET    = 8'h80;
    localparam logic [7:0]  ACT_MAX_RESET    = 8'h7F;

    // Signed 6-bit shift limited to [-31, 30] so the shifters never see 32 or 31-left.
    function automatic logic [5:0] sat_shift(input logic [5:0] raw);
        if (raw == 6'b100000) begin
            return 6'b100001;
        end else if (raw == 6'b011111) begin
            return 6'b011110;
        end else begin
            return raw;
        end
    endfunction

endpackage

// File: rtl/requant_srdhm.sv
// Saturating rounding doubling high multiply with a registered result.
// The only overflowing operand pair (both most-negative) saturates to max positive.
module requant_srdhm (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] m
);

    logic signed [63:0] a_ext;
    logic signed [63:0] b_ext;
    logic signed [63:0] prod;
    logic signed [63:0] nudge;
    logic signed [63:0] sum;
    logic signed [63:0] biased;
    logic               saturate;
    logic [31:0]        m_next;
    logic [31:0]        unused_bits;

    // Biasing negative sums by 2^31-1 turns the arithmetic shift into truncation toward zero.
    always_comb begin
        a_ext    = {{32{a[31]}}, a};
        b_ext    = {{32{b[31]}}, b};
        prod     = a_ext * b_ext;
        nudge    = prod[63] ? 64'shFFFF_FFFF_C000_0001 : 64'sh0000_0000_4000_0000;
        sum      = prod + nudge;
        biased   = sum[63] ? (sum + 64'sh0000_0000_7FFF_FFFF) : sum;
        saturate = (a == 32'h8000_0000) && (b == 32'h8000_0000);
        m_next   = saturate ? 32'h7FFF_FFFF : biased[62:31];
    end

    assign unused_bits = {biased[63], biased[30:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            m <= 32'd0;
        end else if (en) begin
            m <= m_next;
        end
    end

endmodule

// File: rtl/cfu_requant.sv
// Requantization CFU stage: bias add, fixed-point rescale, rounding shift,
// output offset and activation clamp, returned as a sign-extended int8.
module cfu_requant
    import cfu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [9:0]  cmd_payload_function_id,
    input  logic [31:0] cmd_payload_inputs_0,
    input  logic [31:0] cmd_payload_inputs_1,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_payload_outputs_0
);

    state_t             state, state_next;
    logic [6:0]         funct7;
    logic [2:0]         unused_fn_bits;
    logic               accept;
    logic [31:0]        mult;
    logic [5:0]         shift;
    logic [15:0]        out_offset;
    logic [7:0]         act_min, act_max;
    logic [31:0]        op_a, op_b;
    logic               is_requant;
    logic [31:0]        x1;
    logic [31:0]        m;
    logic [31:0]        result;
    logic [4:0]         ls, rs;
    logic [31:0]        mask, rem, thr, m_shr, r;
    logic signed [32:0] v, min_ext, max_ext, lo_clamped, y;
    logic [24:0]        unused_y_bits;
    logic [31:0]        result_next;

    assign funct7         = cmd_payload_function_id[9:3];
    assign unused_fn_bits = cmd_payload_function_id[2:0];
    assign cmd_ready      = (state == ST_IDLE);
    assign rsp_valid      = (state == ST_RESP);
    assign accept         = cmd_valid && cmd_ready;
    assign rsp_payload_outputs_0 = result;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Config commands pass through RND so their response lands one cycle after accept.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (cmd_valid) state_next = (funct7 == FN_REQUANT) ? ST_ADD : ST_RND;
            ST_ADD:  state_next = ST_MUL;
            ST_MUL:  state_next = ST_RND;
            ST_RND:  state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mult       <= MULT_RESET;
            shift      <= SHIFT_RESET;
            out_offset <= OUT_OFFSET_RESET;
            act_min    <= ACT_MIN_RESET;
            act_max    <= ACT_MAX_RESET;
            op_a       <= 32'd0;
            op_b       <= 32'd0;
            is_requant <= 1'b0;
        end else if (accept) begin
            op_a       <= cmd_payload_inputs_0;
            op_b       <= cmd_payload_inputs_1;
            is_requant <= (funct7 == FN_REQUANT);
            if (funct7 == FN_SET_SCALE) begin
                mult  <= cmd_payload_inputs_0;
                shift <= sat_shift(cmd_payload_inputs_1[5:0]);
            end else if (funct7 == FN_SET_OUT) begin
                out_offset <= cmd_payload_inputs_0[15:0];
                act_min    <= cmd_payload_inputs_1[7:0];
                act_max    <= cmd_payload_inputs_1[15:8];
            end
        end
    end

    assign ls = shift[5] ? 5'd0 : shift[4:0];
    assign rs = shift[5] ? (~shift[4:0] + 5'd1) : 5'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            x1 <= 32'd0;
        end else if (state == ST_ADD) begin
            x1 <= (op_a + op_b) << ls;
        end
    end

    requant_srdhm u_srdhm (
        .clk   (clk),
        .reset (reset),
        .en    (state == ST_MUL),
        .a     (x1),
        .b     (mult),
        .m     (m)
    );

    // Round-half-away-from-zero right shift, then offset and clamp in 33 bits so nothing wraps.
    always_comb begin
        mask       = (32'd1 << rs) - 32'd1;
        rem        = m & mask;
        thr        = (mask >> 1) + {31'd0, m[31]};
        m_shr      = $signed(m) >>> rs;
        r          = m_shr + {31'd0, (rem > thr)};
        v          = $signed({r[31], r}) + $signed({{17{out_offset[15]}}, out_offset});
        min_ext    = $signed({{25{act_min[7]}}, act_min});
        max_ext    = $signed({{25{act_max[7]}}, act_max});
        lo_clamped = (v < min_ext) ? min_ext : v;
        y          = (lo_clamped > max_ext) ? max_ext : lo_clamped;
        result_next = {{24{y[7]}}, y[7:0]};
    end

    assign unused_y_bits = y[32:8];

    always_ff @(posedge clk) begin
        if (reset) begin
            result <= 32'd0;
        end else if (state == ST_RND) begin
            result <= is_requant ? result_next : 32'd0;
        end
    end

endmodule

// File: tb/tb_cfu_requant.sv
// Scoreboard bench for cfu_requant: directed commands push hand-computed
// responses; a negedge monitor pops and compares on every response handshake.
module tb_cfu_requant;
    import cfu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_payload_function_id;
    logic [31:0] cmd_payload_inputs_0;
    logic [31:0] cmd_payload_inputs_1;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_payload_outputs_0;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    cfu_requant dut (
        .clk                     (clk),
        .reset                   (reset),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .rsp_payload_outputs_0   (rsp_payload_outputs_0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: each response handshake consumes one scoreboard entry.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_rsp: got 0x%08h, expected no response", rsp_payload_outputs_0);
            end else begin
                checkOutput("rsp_payload", rsp_payload_outputs_0, exp_q.pop_front());
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [6:0] fn, input logic [31:0] a,
                                 input logic [31:0] b, input logic [31:0] expected,
                                 input int exp_lat, input int stall);
        int n;
        int good;
        @(negedge clk);
        rsp_ready = (stall == 0);
        cmd_valid = 1'b1;
        cmd_payload_function_id = {fn, 3'($urandom_range(0, 7))};
        cmd_payload_inputs_0 = a;
        cmd_payload_inputs_1 = b;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_ready"}, {31'd0, cmd_ready}, 32'd1);
        @(posedge clk);
        exp_q.push_back(expected);
        #1;
        cmd_valid = 1'b0;
        cmd_payload_function_id = 10'h3FF;
        cmd_payload_inputs_0 = 32'hDEAD_BEEF;
        cmd_payload_inputs_1 = 32'h1234_5678;
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_latency"}, n, exp_lat);
        if (stall > 0) begin
            good = 0;
            for (int i = 0; i < stall; i++) begin
                if (rsp_valid && rsp_payload_outputs_0 == expected && !cmd_ready) good++;
                @(posedge clk);
                #1;
            end
            checkOutput({name, "_stall_hold"}, good, stall);
            rsp_ready = 1'b1;
        end
        n = 0;
        while (rsp_valid && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput({name, "_drained"}, exp_q.size(), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int accepts;
        int seen;
        reset = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        cmd_payload_function_id = 10'd0;
        cmd_payload_inputs_0 = 32'd0;
        cmd_payload_inputs_1 = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        checkOutput("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("reset_payload", rsp_payload_outputs_0, 32'd0);

        applyStimulus("scale_a", FN_SET_SCALE, 32'h4000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0);
        applyStimulus("rq_clamp", FN_REQUANT, 32'd1000, 32'd0, 32'd127, 3, 0);
        applyStimulus("out_a", FN_SET_OUT, 32'h0000_FF80, 32'h0000_7F80, 32'd0, 1, 0);
        applyStimulus("rq_offset", FN_REQUANT, 32'd900, 32'd100, 32'd122, 3, 0);
        applyStimulus("unknown", 7'd5, 32'h1111_1111, 32'h2222_2222, 32'd0, 1, 0);
        applyStimulus("rq_after_unk", FN_REQUANT, 32'd1000, 32'd0, 32'd122, 3, 0);
        applyStimulus("scale_b", FN_SET_SCALE, 32'h4000_0000, 32'hFFFF_FFFE, 32'd0, 1, 0);
        applyStimulus("out_b", FN_SET_OUT, 32'd0, 32'h0000_7F80, 32'd0, 1, 0);
        applyStimulus("rq_neg_rs2", FN_REQUANT, 32'hFFFF_FFFA, 32'd0, 32'hFFFF_FFFF, 3, 0);
        applyStimulus("scale_c", FN_SET_SCALE, 32'h4000_0000, 32'd0, 32'd0, 1, 0);
        applyStimulus("rq_neg_rs0", FN_REQUANT, 32'hFFFF_FFFD, 32'd0, 32'hFFFF_FFFF, 3, 0);
        applyStimulus("scale_sat", FN_SET_SCALE, 32'h7FFF_FFFF, 32'h0000_0020, 32'd0, 1, 0);
        applyStimulus("rq_rs31", FN_REQUANT, 32'h4000_0000, 32'd0, 32'd1, 3, 0);
        applyStimulus("out_swap", FN_SET_OUT, 32'd0, 32'h0000_0A14, 32'd0, 1, 0);
        applyStimulus("rq_min_gt_max", FN_REQUANT, 32'd0, 32'd0, 32'd10, 3, 0);
        applyStimulus("out_big", FN_SET_OUT, 32'h0000_7FFF, 32'h0000_7F80, 32'd0, 1, 0);
        applyStimulus("scale_d", FN_SET_SCALE, 32'h8000_0000, 32'd0, 32'd0, 1, 0);
        applyStimulus("rq_saturate", FN_REQUANT, 32'h8000_0000, 32'd0, 32'd127, 3, 5);

        // cmd_valid held high: one accept every three cycles, each answered once.
        accepts = 0;
        rsp_ready = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_payload_function_id = {FN_SET_OUT, 3'b000};
        cmd_payload_inputs_0 = 32'd0;
        cmd_payload_inputs_1 = 32'h0000_7F80;
        for (int i = 0; i < 30; i++) begin
            if (cmd_ready) begin
                accepts++;
                exp_q.push_back(32'd0);
            end
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checkOutput("held_accepts", accepts, 32'd10);
        checkOutput("held_drained", exp_q.size(), 32'd0);
        exp_q.delete();

        // Reset with a REQUANT in flight must swallow it.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_payload_function_id = {FN_REQUANT, 3'b000};
        cmd_payload_inputs_0 = 32'd1000;
        cmd_payload_inputs_1 = 32'd0;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid) seen++;
            @(posedge clk);
            #1;
        end
        checkOutput("midreset_no_rsp", seen, 32'd0);
        checkOutput("midreset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        checkOutput("midreset_payload", rsp_payload_outputs_0, 32'd0);
        applyStimulus("rq_after_reset", FN_REQUANT, 32'd100, 32'd0, 32'd0, 3, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cfu_requant.md
# cfu_requant

Post-accumulation requantization stage for the int8 convolution CFU path. Software passes the 32-bit MAC sum from the SIMD multiply-accumulate CFU plus the per-channel bias. The block applies a TFLM-compatible fixed-point rescale: saturating rounding doubling high multiply, then rounding right shift. It then adds the output offset and clamps to the activation range, returning a sign-extended int8. Same cmd/rsp handshake as the other CFU stages, one command in flight, multi-cycle.

## Interface
- No parameters.
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  block can accept a command.
- cmd_payload_function_id  in  10  funct7 = [9:3]; [2:0] ignored.
- cmd_payload_inputs_0  in  32  operand A.
- cmd_payload_inputs_1  in  32  operand B.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  host accepts response.
- rsp_payload_outputs_0  out  32  result.

## Operation
- funct7 0 REQUANT: acc = inputs_0, bias = inputs_1.
  - x = acc + bias, 32-bit wrapping.
  - ls = max(shift,0), rs = max(−shift,0); x1 = x << ls, 32-bit wrap.
  - SRDHM: if x1 == mult == 0x80000000, m = 0x7FFFFFFF.
    - Otherwise p = x1*mult (64-bit signed), nudge = p≥0 ? 2^30 : 1−2^30.
    - m = (p+nudge)/2^31, truncating toward zero, low 32 bits.
  - RDBPOT: mask = 2^rs−1, rem = m & mask, thr = (mask>>1) + (m<0).
    - r = (m >>> rs) + (rem > thr).
  - v = r + out_offset, 33-bit signed, no wrap.
  - y = min(max(v, act_min), act_max).
  - Output is y sign-extended to 32 bits.
- funct7 1 SET_SCALE: mult ← inputs_0; shift ← signed inputs_1[5:0], saturated to [−31, 30]. Response 0.
- funct7 2 SET_OUT: out_offset ← inputs_0[15:0] signed; act_min ← inputs_1[7:0] signed; act_max ← inputs_1[15:8] signed. Response 0.
- Other funct7: no state change, response 0.
- Config reset values: mult 0, shift 0, out_offset 0, act_min −128, act_max 127.
- act_min > act_max is not rejected; act_max wins per the formula above.
- Config registers are written at accept. A following REQUANT uses the new values.

## Timing
- FSM states:
  - IDLE: cmd_ready = 1 only here and only when rsp_valid = 0.
  - ADD: x, x1 registered.
  - MUL: 64-bit product, nudged and truncated m registered.
  - RND: shift, offset and clamp; result registered.
  - RESP: rsp_valid = 1.
- REQUANT accepted at edge N → rsp_valid high after edge N+3.
- Config and unknown commands: rsp_valid high after edge N+1.
- rsp_valid and rsp_payload_outputs_0 hold until rsp_valid && rsp_ready. Return to IDLE on that edge.
- Next command can be accepted one cycle after the response handshake, never on the handshake cycle.
- cmd_payload_* is sampled only at accept and may change afterwards.
- rsp_ready is ignored while rsp_valid = 0.
- Reset values: rsp_valid 0, rsp_payload_outputs_0 0, FSM IDLE, config at defaults.
- Reset mid-operation discards the in-flight command; no response is produced.
- cmd_ready is combinational from state, not from cmd_valid.

## Structure
- cfu_pkg holds:
  - funct7 constants FN_REQUANT = 0, FN_SET_SCALE = 1, FN_SET_OUT = 2.
  - FSM state enum.
  - Config reset constants.
- Sub-module requant_srdhm: registered 32×32 signed multiply, nudge and truncation, with saturation special case. Instantiated as the MUL stage and reusable by later per-channel pipelines.
- Rounding shift, offset and clamp stay inline in cfu_requant.

## Test plan
- Reset, then idle: rsp_valid = 0, cmd_ready = 1, output 0. After SET_SCALE(mult 0x40000000, shift −1), REQUANT(1000, 0): first response after N+1 is 0, REQUANT output 127 (r = 250, clamped).
- Set offsets with SET_OUT(0xFF80, 0x7F80), then REQUANT(1000, 0) → 122.
- SET_SCALE(0x40000000, −2), SET_OUT(0, 0x7F80), REQUANT(−6, 0) → 0xFFFFFFFF (−1). SET_SCALE(0x40000000, 0), REQUANT(−3, 0) → 0xFFFFFFFF (−1).
- SET_SCALE(0x80000000, 0), REQUANT(0x80000000, 0) → saturation path → 127.
- Handshake stalls:
  - Hold rsp_ready = 0 for 5 cycles: rsp_valid and payload stable, cmd_ready = 0.
  - Hold cmd_valid high throughout: exactly one accept per response.
- Assert reset one cycle after REQUANT accept: no rsp_valid. Next REQUANT(100, 0) returns 0, since mult reset to 0.
